tlb_ptw: RTL

- Hardware page-table walker sitting directly downstream of the TLB controller's PTW interface.
- Accepts one VPN per TLB miss, performs a two-level Sv32-style walk through a single-outstanding memory port, and returns the leaf PPN, permission flags, page level and fault status.
- The returned values are installed by the TLB in its UPDATE state.

---
 rtl/tlb_ptw_pkg.sv | 31 +++
 rtl/tlb_ptw_pte_check.sv | 39 +++
 rtl/tlb_ptw.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tlb_ptw_pkg.sv
// Shared definitions for the tlb_ptw page-table walker: FSM state encoding,
// PTE flag bit positions and Sv32 field geometry.
package tlb_ptw_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_L1_REQ  = 3'd1,
        S_L1_WAIT = 3'd2,
        S_L0_REQ  = 3'd3,
        S_L0_WAIT = 3'd4,
        S_RESP    = 3'd5
    } ptw_state_e;

    // PTE flag positions, {D,A,G,U,X,W,R,V}
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam int PTE_PPN_LSB   = 10;
    localparam int PTE_PPN_MSB   = 31;
    localparam int PAGE_OFFSET   = 12;
    localparam int VPN_IDX_W     = 10;
    localparam int PTE_IDX_SHIFT = 2;
    localparam int PERM_W        = 8;

endpackage

// File: rtl/tlb_ptw_pte_check.sv
// Combinational PTE decode shared by both walk levels: classifies the entry as
// leaf / pointer and flags every fault condition for the given level.
module tlb_ptw_pte_check
    import tlb_ptw_pkg::*;
#(
    parameter int PTE_WIDTH = 32,
    parameter int PPN_WIDTH = 22
) (
    input  logic [PTE_WIDTH-1:0] pte,
    input  logic                 level,
    input  logic                 err,
    output logic                 is_leaf,
    output logic                 fault,
    output logic [PPN_WIDTH-1:0] next_ppn
);

    logic v;
    logic r;
    logic w;
    logic x;
    logic misaligned;
    logic unused_rsw;

    // RSW bits carry no meaning for the walker
    assign unused_rsw = ^pte[PTE_PPN_LSB-1:PTE_D+1];

    always_comb begin
        v          = pte[PTE_V];
        r          = pte[PTE_R];
        w          = pte[PTE_W];
        x          = pte[PTE_X];
        is_leaf    = r | x;
        next_ppn   = pte[PTE_PPN_LSB +: PPN_WIDTH];
        misaligned = level && is_leaf && (pte[PTE_PPN_LSB +: VPN_IDX_W] != '0);
        // a pointer at level 0 has nowhere left to go
        fault      = err | ~v | (~r & w) | misaligned | (~level & ~is_leaf);
    end

endmodule

// File: rtl/tlb_ptw.sv
// Two-level Sv32-style hardware page-table walker with a single-outstanding
// PTE read port; every output is a register updated alongside the next state.
module tlb_ptw
    import tlb_ptw_pkg::*;
#(
    parameter int PA_WIDTH  = 34,
    parameter int PPN_WIDTH = 22,
    parameter int VPN_WIDTH = 20,
    parameter int PTE_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PPN_WIDTH-1:0] satp_ppn_i,
    input  logic                 ptw_req_valid_i,
    output logic                 ptw_req_ready_o,
    input  logic [VPN_WIDTH-1:0] ptw_req_vpn_i,
    output logic                 ptw_resp_valid_o,
    input  logic                 ptw_resp_ready_i,
    output logic [PPN_WIDTH-1:0] ptw_resp_ppn_o,
    output logic [PERM_W-1:0]    ptw_resp_perm_o,
    output logic                 ptw_resp_level_o,
    output logic                 ptw_resp_fault_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [PA_WIDTH-1:0]  mem_req_addr_o,
    input  logic                 mem_resp_valid_i,
    output logic                 mem_resp_ready_o,
    input  logic [PTE_WIDTH-1:0] mem_resp_data_i,
    input  logic                 mem_resp_err_i
);

    ptw_state_e           state;
    logic [VPN_WIDTH-1:0] vpn_q;

    logic                 chk_leaf;
    logic                 chk_fault;
    logic [PPN_WIDTH-1:0] chk_ppn;

    tlb_ptw_pte_check #(
        .PTE_WIDTH (PTE_WIDTH),
        .PPN_WIDTH (PPN_WIDTH)
    ) u_pte_check (
        .pte      (mem_resp_data_i),
        .level    (state == S_L1_WAIT),
        .err      (mem_resp_err_i),
        .is_leaf  (chk_leaf),
        .fault    (chk_fault),
        .next_ppn (chk_ppn)
    );

    // PTE address = table base + index * 4, wrapping at PA_WIDTH
    function automatic logic [PA_WIDTH-1:0] pte_addr(input logic [PPN_WIDTH-1:0] ppn,
                                                     input logic [VPN_IDX_W-1:0] idx);
        logic [PA_WIDTH-1:0] base;
        logic [PA_WIDTH-1:0] offs;
        base = PA_WIDTH'({ppn, {PAGE_OFFSET{1'b0}}});
        offs = PA_WIDTH'({idx, {PTE_IDX_SHIFT{1'b0}}});
        return base + offs;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            vpn_q            <= '0;
            ptw_req_ready_o  <= 1'b1;
            ptw_resp_valid_o <= 1'b0;
            ptw_resp_ppn_o   <= '0;
            ptw_resp_perm_o  <= '0;
            ptw_resp_level_o <= 1'b0;
            ptw_resp_fault_o <= 1'b0;
            mem_req_valid_o  <= 1'b0;
            mem_req_addr_o   <= '0;
            mem_resp_ready_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ptw_req_valid_i) begin
                        vpn_q           <= ptw_req_vpn_i;
                        mem_req_addr_o  <= pte_addr(satp_ppn_i,
                                                    ptw_req_vpn_i[VPN_WIDTH-1:VPN_IDX_W]);
                        mem_req_valid_o <= 1'b1;
                        ptw_req_ready_o <= 1'b0;
                        state           <= S_L1_REQ;
                    end
                end
                S_L1_REQ, S_L0_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o  <= 1'b0;
                        mem_resp_ready_o <= 1'b1;
                        state            <= (state == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                    end
                end
                S_L1_WAIT, S_L0_WAIT: begin
                    if (mem_resp_valid_i) begin
                        mem_resp_ready_o <= 1'b0;
                        if (chk_fault) begin
                            ptw_resp_fault_o <= 1'b1;
                            ptw_resp_ppn_o   <= '0;
                            ptw_resp_perm_o  <= '0;
                            ptw_resp_level_o <= 1'b0;
                            ptw_resp_valid_o <= 1'b1;
                            state            <= S_RESP;
                        end else if (chk_leaf) begin
                            // superpage: low PPN half comes from VPN0
                            ptw_resp_ppn_o   <= (state == S_L1_WAIT)
                                              ? {chk_ppn[PPN_WIDTH-1:VPN_IDX_W], vpn_q[VPN_IDX_W-1:0]}
                                              : chk_ppn;
                            ptw_resp_perm_o  <= mem_resp_data_i[PERM_W-1:0];
                            ptw_resp_level_o <= (state == S_L1_WAIT);
                            ptw_resp_fault_o <= 1'b0;
                            ptw_resp_valid_o <= 1'b1;
                            state            <= S_RESP;
                        end else begin
                            mem_req_addr_o  <= pte_addr(chk_ppn, vpn_q[VPN_IDX_W-1:0]);
                            mem_req_valid_o <= 1'b1;
                            state           <= S_L0_REQ;
                        end
                    end
                end
                S_RESP: begin
                    if (ptw_resp_ready_i) begin
                        ptw_resp_valid_o <= 1'b0;
                        ptw_resp_ppn_o   <= '0;
                        ptw_resp_perm_o  <= '0;
                        ptw_resp_level_o <= 1'b0;
                        ptw_resp_fault_o <= 1'b0;
                        ptw_req_ready_o  <= 1'b1;
                        state            <= S_IDLE;
                    end
                end
                default: begin
                    state            <= S_IDLE;
                    ptw_req_ready_o  <= 1'b1;
                    ptw_resp_valid_o <= 1'b0;
                    mem_req_valid_o  <= 1'b0;
                    mem_resp_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
